// File: rtl/button_event_conditioner_if.sv
// Button conditioner bus: raw pins and acks in; debounced level,
// sticky interrupt/overrun flags and lowest-pending encoding out.
interface button_event_conditioner_if #(
  parameter int CHANNELS = 20
);
  logic [CHANNELS-1:0] btn_raw;
  logic [CHANNELS-1:0] ack;
  logic [CHANNELS-1:0] level;
  logic [CHANNELS-1:0] interrupt;
  logic [CHANNELS-1:0] overrun;
  logic                irq_valid;
  logic [4:0]          irq_id;

  modport master (
    output btn_raw,
    output ack,
    input  level,
    input  interrupt,
    input  overrun,
    input  irq_valid,
    input  irq_id
  );

  modport slave (
    input  btn_raw,
    input  ack,
    output level,
    output interrupt,
    output overrun,
    output irq_valid,
    output irq_id
  );
endinterface

// File: rtl/button_event_conditioner.sv
// Sync + debounce raw buttons, latch sticky press interrupts.
// Ports: clk, rst_n (async low), bus (slave: btn_raw/ack in, flags out).
module button_event_conditioner #(
  parameter int CHANNELS        = 20,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int ACTIVE_LOW      = 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  button_event_conditioner_if.slave    bus
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] TERM =
    CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CHANNELS-1:0] SYNC_RST =
    (ACTIVE_LOW != 0) ? '1 : '0;

  logic [CHANNELS-1:0] sync1;
  logic [CHANNELS-1:0] sync2;
  logic [CHANNELS-1:0] level_q;
  logic [CHANNELS-1:0] int_q;
  logic [CHANNELS-1:0] ovr_q;
  logic [CW-1:0]       cnt_q [CHANNELS];

  logic [CHANNELS-1:0] pressed;
  logic [CHANNELS-1:0] differ;
  logic [CHANNELS-1:0] term;
  logic [CHANNELS-1:0] press;
  logic [4:0]          id;

  // Sync flops hold the raw pin, so they reset to "released".
  assign pressed = (ACTIVE_LOW != 0) ? ~sync2 : sync2;
  assign differ  = pressed ^ level_q;

  always_comb begin
    term = '0;
    for (int i = 0; i < CHANNELS; i++)
      term[i] = (cnt_q[i] == TERM);
  end

  // Press fires on the same edge that level rises.
  assign press = differ & term & pressed;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1   <= SYNC_RST;
      sync2   <= SYNC_RST;
      level_q <= '0;
      int_q   <= '0;
      ovr_q   <= '0;
      for (int i = 0; i < CHANNELS; i++)
        cnt_q[i] <= '0;
    end else begin
      sync1   <= bus.btn_raw;
      sync2   <= sync1;
      level_q <= level_q ^ (differ & term);
      int_q   <= press | (int_q & ~bus.ack);
      ovr_q   <= (ovr_q | (press & int_q))
                 & ~bus.ack;
      for (int i = 0; i < CHANNELS; i++) begin
        if (!differ[i] || term[i])
          cnt_q[i] <= '0;
        else
          cnt_q[i] <= cnt_q[i] + 1'b1;
      end
    end
  end

  always_comb begin
    id = '0;
    for (int i = CHANNELS - 1; i >= 0; i--)
      if (int_q[i]) id = 5'(i);
  end

  assign bus.level     = level_q;
  assign bus.interrupt = int_q;
  assign bus.overrun   = ovr_q;
  assign bus.irq_valid = |int_q;
  assign bus.irq_id    = id;
endmodule

// File: tb/tb_button_event_conditioner.sv
// Directed bench for button_event_conditioner.
// CHANNELS=20, DEBOUNCE_CYCLES=4, ACTIVE_LOW=1.
module tb_button_event_conditioner;
  logic clk = 1'b0;
  logic rst_n;
  int   nvec = 0;
  int   nbad = 0;

  always #5 clk = ~clk;

  button_event_conditioner_if #(.CHANNELS(20)) bif ();

  button_event_conditioner #(
    .CHANNELS(20),
    .DEBOUNCE_CYCLES(4),
    .ACTIVE_LOW(1)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bif)
  );

  typedef struct {
    logic [19:0] btn;
    logic [19:0] ack;
    logic [19:0] lvl;
    logic [19:0] irq;
    logic [19:0] ovr;
    logic        vld;
    logic [4:0]  id;
  } vec_t;

  vec_t tbl [13];

  task automatic chk(input string nm,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nbad++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  task automatic chk_all(input string nm,
                         input logic [19:0] lvl,
                         input logic [19:0] irq,
                         input logic [19:0] ovr,
                         input logic        vld,
                         input logic [4:0]  id);
    chk({nm, ".level"}, 32'(bif.level), 32'(lvl));
    chk({nm, ".irq"}, 32'(bif.interrupt), 32'(irq));
    chk({nm, ".ovr"}, 32'(bif.overrun), 32'(ovr));
    chk({nm, ".vld"}, 32'(bif.irq_valid), 32'(vld));
    chk({nm, ".id"}, 32'(bif.irq_id), 32'(id));
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic hold(input int ch, input logic v);
    bif.btn_raw[ch] = v;
    repeat (6) cyc();
  endtask

  task automatic ack_pulse(input int ch);
    bif.ack[ch] = 1'b1;
    cyc();
    bif.ack = '0;
  endtask

  logic bad;

  initial begin
    for (int k = 0; k < 13; k++) begin
      tbl[k].btn = (k < 7) ? 20'hFFFF7 : 20'hFFFFF;
      tbl[k].ack = (k == 6) ? 20'h00008 : 20'h0;
      tbl[k].lvl = (k >= 5 && k < 12) ? 20'h8 : 20'h0;
      tbl[k].irq = (k == 5) ? 20'h8 : 20'h0;
      tbl[k].ovr = 20'h0;
      tbl[k].vld = (k == 5);
      tbl[k].id  = (k == 5) ? 5'd3 : 5'd0;
    end

    rst_n = 1'b0;
    bif.btn_raw = 20'hFFFFF;
    bif.ack = '0;
    #3;
    chk_all("rst_async", 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    chk_all("rst_hold", 0, 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) cyc();
    chk_all("idle", 0, 0, 0, 0, 0);

    for (int k = 0; k < 13; k++) begin
      bif.btn_raw = tbl[k].btn;
      bif.ack = tbl[k].ack;
      cyc();
      chk_all($sformatf("tbl%0d", k), tbl[k].lvl,
              tbl[k].irq, tbl[k].ovr, tbl[k].vld,
              tbl[k].id);
    end
    bif.ack = '0;

    for (int r = 0; r < 5; r++) begin
      bad = 1'b0;
      bif.btn_raw[0] = 1'b0;
      repeat (3) begin
        cyc();
        bad |= bif.level[0] | bif.interrupt[0];
      end
      bif.btn_raw[0] = 1'b1;
      repeat (3) begin
        cyc();
        bad |= bif.level[0] | bif.interrupt[0];
      end
      chk($sformatf("bounce%0d", r), 32'(bad), 0);
    end
    bad = 1'b0;
    repeat (6) begin
      cyc();
      bad |= bif.level[0] | bif.interrupt[0];
    end
    chk("bounce_tail", 32'(bad), 0);

    hold(7, 1'b0);
    chk_all("ovr_p1", 20'h80, 20'h80, 0, 1, 7);
    hold(7, 1'b1);
    chk_all("ovr_r1", 0, 20'h80, 0, 1, 7);
    hold(7, 1'b0);
    chk_all("ovr_p2", 20'h80, 20'h80, 20'h80, 1, 7);
    ack_pulse(7);
    chk_all("ovr_ack", 20'h80, 0, 0, 0, 0);
    hold(7, 1'b1);

    bif.btn_raw[5] = 1'b0;
    repeat (5) cyc();
    chk("col_pre", 32'(bif.interrupt), 0);
    bif.ack[5] = 1'b1;
    cyc();
    bif.ack = '0;
    chk_all("col_set", 20'h20, 20'h20, 0, 1, 5);
    hold(5, 1'b1);
    bif.btn_raw[5] = 1'b0;
    repeat (5) cyc();
    bif.ack[5] = 1'b1;
    cyc();
    bif.ack = '0;
    chk_all("col_ovr", 20'h20, 20'h20, 0, 1, 5);
    cyc();
    chk_all("col_hold", 20'h20, 20'h20, 0, 1, 5);
    ack_pulse(5);
    chk_all("col_ack", 20'h20, 0, 0, 0, 0);
    hold(5, 1'b1);

    bif.btn_raw[2] = 1'b0;
    hold(12, 1'b0);
    chk_all("pri_both", 20'h01004, 20'h01004, 0, 1, 2);
    ack_pulse(2);
    chk_all("pri_12", 20'h01004, 20'h01000, 0, 1, 12);
    bif.btn_raw[2] = 1'b1;
    hold(12, 1'b1);
    chk_all("pri_rel", 0, 20'h01000, 0, 1, 12);

    bif.btn_raw[9] = 1'b0;
    repeat (3) cyc();
    #2;
    rst_n = 1'b0;
    #1;
    chk_all("mid_rst", 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      cyc();
      chk($sformatf("post_irq%0d", k),
          32'(bif.interrupt),
          (k == 6) ? 32'h200 : 32'h0);
    end
    repeat (10) cyc();
    chk_all("post_one", 20'h200, 20'h200, 0, 1, 9);

    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nbad);
    $finish;
  end
endmodule
